// File: rtl/multicycle_control.sv
// Multi-cycle processor control FSM: fetch/decode/execute/memory/writeback with
// a bounded memory wait counter and a sticky TRAP state for illegal opcodes and timeouts.
module multicycle_control #(
  parameter int OPCODE_W    = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                mem_read,
  output logic                memwrite,
  output logic                regwrite,
  output logic                reg_dest,
  output logic                memtoreg,
  output logic                alu_src,
  output logic [1:0]          aluop,
  output logic [1:0]          pc_src,
  output logic [2:0]          state,
  output logic                illegal,
  output logic                timeout
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(5);

  state_t              r_state;
  logic [OPCODE_W-1:0] r_op;
  logic [7:0]          r_wait;
  logic                r_illegal;
  logic                r_timeout;

  logic w_opcode_legal;
  logic w_wait_hit;

  assign w_opcode_legal = (opcode <= OP_JMP);
  // The counter holding MEM_TIMEOUT grants one last cycle: ready then still completes.
  assign w_wait_hit     = (r_wait == 8'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_op      <= '0;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_state <= S_DECODE;
          end else if (w_wait_hit) begin
            r_state   <= S_TRAP;
            r_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_DECODE: begin
          r_op   <= opcode;
          r_wait <= '0;
          if (!w_opcode_legal) begin
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
          end else if (opcode == OP_JMP) begin
            r_state <= S_FETCH;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_wait <= '0;
          case (r_op)
            OP_R, OP_ADDI: r_state <= S_WB;
            OP_LD, OP_ST:  r_state <= S_MEM;
            default:       r_state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            r_wait  <= '0;
            r_state <= (r_op == OP_LD) ? S_WB : S_FETCH;
          end else if (w_wait_hit) begin
            r_state   <= S_TRAP;
            r_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_WB: begin
          r_wait  <= '0;
          r_state <= S_FETCH;
        end
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Strobes are gated by rst_n so nothing fires while reset is held.
  always_comb begin
    pc_write = 1'b0;
    ir_write = 1'b0;
    mem_read = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    reg_dest = 1'b0;
    memtoreg = 1'b0;
    alu_src  = 1'b0;
    aluop    = 2'd0;
    pc_src   = 2'd0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_DECODE: begin
          // IR was loaded at the end of FETCH, so the live opcode is valid here.
          if (opcode == OP_JMP) begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
          end
        end
        S_EXEC: begin
          case (r_op)
            OP_ADDI, OP_LD, OP_ST: begin
              aluop   = 2'd1;
              alu_src = 1'b1;
            end
            OP_BEQ: begin
              aluop    = 2'd2;
              pc_src   = 2'd1;
              pc_write = zero;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_read = (r_op == OP_LD);
          memwrite = (r_op == OP_ST);
        end
        S_WB: begin
          regwrite = 1'b1;
          reg_dest = (r_op != OP_R);
          memtoreg = (r_op == OP_LD);
        end
        default: ;
      endcase
    end
  end

  assign state   = r_state;
  assign illegal = r_illegal;
  assign timeout = r_timeout;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OPCODE_W, default 4, opcode width in bits; legal values are 3 to 8.
REQ-002 Parameter MEM_TIMEOUT, default 15, maximum wait cycles for mem_ready; legal values are 1 to 255.
REQ-003 Port clk, input, 1 bit: single clock, rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port opcode, input, OPCODE_W bits: opcode field of the instruction register.
REQ-006 Port zero, input, 1 bit: ALU zero flag.
REQ-007 Port mem_ready, input, 1 bit: memory completes the current access this cycle.
REQ-008 Outputs, 1 bit each: pc_write, ir_write, mem_read, memwrite, regwrite, reg_dest, memtoreg, alu_src.
REQ-009 Outputs aluop (2 bits) and pc_src (2 bits): pc_src 0 selects PC+1, 1 selects the branch target, 2 selects the jump target.
REQ-010 Outputs state (3 bits), illegal (1 bit) and timeout (1 bit), all status.

Function
REQ-011 The block SHALL be a multi-cycle FSM with these state encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-012 Opcode classes SHALL be: 0 R-type, 1 ADDI, 2 LD, 3 ST, 4 BEQ, 5 JMP; every other value is illegal.
REQ-013 In DECODE, op_q SHALL latch opcode; later states decode op_q only.
REQ-014 FETCH SHALL assert mem_read=1 and hold while mem_ready=0.
REQ-015 In FETCH with mem_ready=1, the block SHALL assert ir_write=1 and pc_write=1 (pc_src=0) in that same cycle, then go to DECODE.
REQ-016 DECODE SHALL last 1 cycle: an illegal opcode goes to TRAP; JMP asserts pc_write=1 with pc_src=2 and goes to FETCH; all others go to EXEC.
REQ-017 In EXEC, R-type SHALL output aluop=0, alu_src=0, reg_dest=0, then go to WB.
REQ-018 In EXEC, ADDI SHALL output aluop=1, alu_src=1, then go to WB.
REQ-019 In EXEC, LD and ST SHALL output aluop=1, alu_src=1 (address calculation), then go to MEM.
REQ-020 In EXEC, BEQ SHALL output aluop=2, alu_src=0, pc_src=1, pc_write=zero, then go to FETCH.
REQ-021 In MEM for LD, the block SHALL assert mem_read=1 until mem_ready=1, then go to WB.
REQ-022 In MEM for ST, the block SHALL assert memwrite=1 until mem_ready=1, then go to FETCH.
REQ-023 WB SHALL assert regwrite=1 for exactly 1 cycle, with reg_dest=0 for R-type and 1 otherwise and memtoreg=1 only for LD, then go to FETCH.
REQ-024 Outputs SHALL be combinational decodes of state and op_q; the only input-dependent terms are the mem_ready gating and BEQ's use of zero.
REQ-025 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_ready=0; if it reaches MEM_TIMEOUT, the FSM goes to TRAP and sets timeout=1.
REQ-026 When mem_ready=1 arrives on the same cycle as the count reaches MEM_TIMEOUT, the access SHALL complete normally with no timeout.
REQ-027 TRAP SHALL be sticky until reset: every strobe is 0, and illegal or timeout holds whichever was the cause.
REQ-028 In every state, memwrite and regwrite SHALL never both be 1, and mem_read and memwrite SHALL never both be 1.
REQ-029 Latency without waits SHALL be: R-type and ADDI 4 cycles, LD 5, ST 4, BEQ 3, JMP 2.

Reset
REQ-030 rst_n=0 SHALL immediately force state=FETCH, op_q=0, wait counter=0, illegal=0 and timeout=0, regardless of clk.
REQ-031 During reset every strobe output SHALL be 0; mem_read rises only after rst_n deasserts.
REQ-032 Reset asserted mid-access, including in MEM during a store, SHALL abandon the instruction with no further memwrite.

Verification
REQ-033 Drive opcode=0 with mem_ready=1 throughout -> FETCH, DECODE, EXEC, WB, FETCH; regwrite=1 only in cycle 4, reg_dest=0.
REQ-034 Drive opcode=2 with mem_ready low for 3 cycles in MEM -> mem_read held 4 cycles in MEM, then WB with memtoreg=1; total 8 cycles.
REQ-035 Drive opcode=4 with zero=1, then again with zero=0 -> pc_write=1 with pc_src=1 in EXEC for the first case only; both cases reach FETCH after 3 cycles.
REQ-036 Drive opcode=7 -> TRAP after DECODE with illegal=1; the FSM stays there for 20 cycles with all strobes 0.
REQ-037 Drive mem_ready=0 in FETCH with MEM_TIMEOUT=15 -> TRAP after cycle 15 with timeout=1; mem_ready=1 at count 15 instead gives normal DECODE.
REQ-038 Pulse rst_n low while in MEM during ST -> memwrite drops immediately and state=0; the FSM resumes with FETCH after release.
